// File: rtl/conv_feeder_pkg.sv
// Shared types and widths for the ConvPE3x3 source-side feeder.
package conv_feeder_pkg;

  localparam int PIX_W  = 8;
  localparam int WIN_W  = 24;
  localparam int PSUM_W = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2
  } feeder_state_t;

  // Shift a new pixel into the low lane of a window; the oldest pixel falls out of [23:16].
  function automatic logic [WIN_W-1:0] next_window(input logic [WIN_W-1:0] win,
                                                   input logic [PIX_W-1:0] px);
    return {win[WIN_W-PIX_W-1:0], px};
  endfunction

endpackage

// File: rtl/conv_pe_feeder_window_shift3.sv
// Three-pixel shift register holding the most recent pixels of the current row.
module window_shift3
  import conv_feeder_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [WIN_W-1:0] q
);

  logic [WIN_W-1:0] win_r;

  // Clear has priority so a new job never sees pixels from an aborted row.
  always_ff @(posedge clk) begin
    if (clr) begin
      win_r <= {WIN_W{1'b0}};
    end else if (en) begin
      win_r <= next_window(win_r, din);
    end
  end

  assign q = win_r;

endmodule

// File: rtl/conv_pe_feeder.sv
// Loads one kernel row into a ConvPE3x3, then streams stride-1 unpadded 3-pixel
// windows of one image row with a compute enable.
module conv_pe_feeder
  import conv_feeder_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IDX_W = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [WIN_W-1:0] w_data,
  input  logic             px_valid,
  output logic             px_ready,
  input  logic [PIX_W-1:0] px_data,
  output logic             pe_weight_en,
  output logic [WIN_W-1:0] pe_in2,
  output logic             pe_ce,
  output logic [WIN_W-1:0] pe_in1,
  output logic [IDX_W-1:0] win_idx
);

  if ((IMG_W < 3) || (IMG_W > 1024)) begin : g_bad_img_w
    $error("conv_pe_feeder: IMG_W=%0d outside legal range 3..1024", IMG_W);
  end

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0] FIRST_WIN = IDX_W'(2);

  feeder_state_t    state_r;
  logic [IDX_W-1:0] cnt_r;
  logic             busy_r, done_r, w_ready_r, px_ready_r;
  logic             weight_en_r, ce_r;
  logic [WIN_W-1:0] in1_r, in2_r;
  logic [IDX_W-1:0] idx_r;
  logic             px_hs_s, win_clr_s;
  logic [WIN_W-1:0] win_s;

  assign px_hs_s   = (state_r == STREAM) && px_valid && px_ready_r;
  // The window history restarts with every weight load as well as on reset.
  assign win_clr_s = !rst_n || (state_r == LOAD_W);

  window_shift3 u_win (
    .clk (clk),
    .clr (win_clr_s),
    .en  (px_hs_s),
    .din (px_data),
    .q   (win_s)
  );

  // Job FSM, pixel counter and all registered PE-facing outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {IDX_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      w_ready_r   <= 1'b0;
      px_ready_r  <= 1'b0;
      weight_en_r <= 1'b0;
      ce_r        <= 1'b0;
      in1_r       <= {WIN_W{1'b0}};
      in2_r       <= {WIN_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
    end else begin
      weight_en_r <= 1'b0;
      ce_r        <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= LOAD_W;
            busy_r    <= 1'b1;
            w_ready_r <= 1'b1;
          end
        end
        LOAD_W: begin
          if (w_valid && w_ready_r) begin
            state_r     <= STREAM;
            w_ready_r   <= 1'b0;
            px_ready_r  <= 1'b1;
            weight_en_r <= 1'b1;
            in2_r       <= w_data;
            cnt_r       <= {IDX_W{1'b0}};
          end
        end
        STREAM: begin
          if (px_hs_s) begin
            if (cnt_r >= FIRST_WIN) begin
              ce_r  <= 1'b1;
              in1_r <= next_window(win_s, px_data);
              idx_r <= cnt_r - FIRST_WIN;
            end
            if (cnt_r == LAST_IDX) begin
              state_r    <= IDLE;
              busy_r     <= 1'b0;
              px_ready_r <= 1'b0;
              done_r     <= 1'b1;
              cnt_r      <= {IDX_W{1'b0}};
            end else begin
              cnt_r <= cnt_r + IDX_W'(1);
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          w_ready_r  <= 1'b0;
          px_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign w_ready      = w_ready_r;
  assign px_ready     = px_ready_r;
  assign pe_weight_en = weight_en_r;
  assign pe_in2       = in2_r;
  assign pe_ce        = ce_r;
  assign pe_in1       = in1_r;
  assign win_idx      = idx_r;

endmodule

// File: tb/tb_conv_pe_feeder.sv
// Directed self-checking bench: three feeder instances (IMG_W=5, 8, 3) share the data
// inputs; each only reacts once its own start is pulsed.
module tb_conv_pe_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start5, start8, start3;
  logic        w_valid, px_valid;
  logic [23:0] w_data;
  logic [7:0]  px_data;

  logic busy5, done5, w_ready5, px_ready5, pe_weight_en5, pe_ce5;
  logic busy8, done8, w_ready8, px_ready8, pe_weight_en8, pe_ce8;
  logic busy3, done3, w_ready3, px_ready3, pe_weight_en3, pe_ce3;
  logic [23:0] pe_in1_5, pe_in2_5, pe_in1_8, pe_in2_8, pe_in1_3, pe_in2_3;
  logic [2:0]  win_idx5, win_idx8;
  logic [1:0]  win_idx3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [23:0] win;
    int          idx;
    logic        dn;
    logic [23:0] wt;
    int          cyc;
  } rec_t;

  rec_t q5[$];
  rec_t q8[$];
  int dcnt5, dcnt8, wcnt5;

  conv_pe_feeder #(.IMG_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .busy(busy5), .done(done5),
    .w_valid(w_valid), .w_ready(w_ready5), .w_data(w_data),
    .px_valid(px_valid), .px_ready(px_ready5), .px_data(px_data),
    .pe_weight_en(pe_weight_en5), .pe_in2(pe_in2_5), .pe_ce(pe_ce5),
    .pe_in1(pe_in1_5), .win_idx(win_idx5)
  );

  conv_pe_feeder #(.IMG_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
    .w_valid(w_valid), .w_ready(w_ready8), .w_data(w_data),
    .px_valid(px_valid), .px_ready(px_ready8), .px_data(px_data),
    .pe_weight_en(pe_weight_en8), .pe_in2(pe_in2_8), .pe_ce(pe_ce8),
    .pe_in1(pe_in1_8), .win_idx(win_idx8)
  );

  conv_pe_feeder #(.IMG_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .w_valid(w_valid), .w_ready(w_ready3), .w_data(w_data),
    .px_valid(px_valid), .px_ready(px_ready3), .px_data(px_data),
    .pe_weight_en(pe_weight_en3), .pe_in2(pe_in2_3), .pe_ce(pe_ce3),
    .pe_in1(pe_in1_3), .win_idx(win_idx3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor recording every compute-enable cycle and pulse counts.
  always @(negedge clk) begin
    if (pe_ce5 === 1'b1) q5.push_back('{pe_in1_5, int'(win_idx5), done5, pe_in2_5, cyc});
    if (pe_ce8 === 1'b1) q8.push_back('{pe_in1_8, int'(win_idx8), done8, pe_in2_8, cyc});
    if (done5 === 1'b1) dcnt5++;
    if (done8 === 1'b1) dcnt8++;
    if (pe_weight_en5 === 1'b1) wcnt5++;
  end

  // Reference ConvPE3x3 dot product of a window and a kernel row.
  function automatic logic [17:0] pe_out(input logic [23:0] a, input logic [23:0] k);
    return 18'(a[23:16]) * 18'(k[23:16]) + 18'(a[15:8]) * 18'(k[15:8]) + 18'(a[7:0]) * 18'(k[7:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start5 = 1'b0; start8 = 1'b0; start3 = 1'b0;
    w_valid = 1'b0; px_valid = 1'b0; w_data = 24'h0; px_data = 8'h0;
    step();
    rst_n = 1'b1;
    q5.delete(); q8.delete();
    dcnt5 = 0; dcnt8 = 0; wcnt5 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start5 = 1'b1; start8 = 1'b0; start3 = 1'b0;
    w_valid = 1'b1; px_valid = 1'b1; w_data = 24'hABCDEF; px_data = 8'h55;
    step();
    checks++;
    if ({busy5, done5, w_ready5, px_ready5, pe_weight_en5, pe_ce5} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl5: got %b want 000000", {busy5, done5, w_ready5, px_ready5, pe_weight_en5, pe_ce5});
    end
    checks++;
    if ({pe_in2_5, pe_in1_5, win_idx5} !== 51'h0) begin
      errors++; $display("FAIL reset_data5: in2=%h in1=%h idx=%0d want 0", pe_in2_5, pe_in1_5, win_idx5);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_win;
    logic [17:0] exp_out[3] = '{18'd14, 18'd20, 18'd26};
    do_reset();
    start5 = 1'b1; step(); start5 = 1'b0;
    checks++;
    if ({w_ready5, busy5} !== 2'b11) begin errors++; $display("FAIL b2b_load_w: w_ready,busy=%b want 11", {w_ready5, busy5}); end
    w_valid = 1'b1; w_data = 24'h010203; step(); w_valid = 1'b0;
    checks++;
    if ({pe_weight_en5, px_ready5, w_ready5} !== 3'b110) begin
      errors++; $display("FAIL b2b_whs: wen,px_ready,w_ready=%b want 110", {pe_weight_en5, px_ready5, w_ready5});
    end
    checks++;
    if (pe_in2_5 !== 24'h010203) begin errors++; $display("FAIL b2b_in2: got %h want 010203", pe_in2_5); end
    for (int p = 1; p <= 5; p++) begin
      px_valid = 1'b1; px_data = 8'(p); step();
    end
    px_valid = 1'b0;
    checks++;
    if ({done5, busy5, px_ready5, pe_ce5} !== 4'b1001) begin
      errors++; $display("FAIL b2b_last: done,busy,px_ready,ce=%b want 1001", {done5, busy5, px_ready5, pe_ce5});
    end
    step(); step();
    checks++;
    if (q5.size() != 3) begin errors++; $display("FAIL b2b_nwin: got %0d want 3", q5.size()); end
    for (int i = 0; i < q5.size() && i < 3; i++) begin
      exp_win = {8'(i + 1), 8'(i + 2), 8'(i + 3)};
      checks++;
      if (q5[i].win !== exp_win || q5[i].idx != i || q5[i].dn !== (i == 2)) begin
        errors++; $display("FAIL b2b_win%0d: win=%h idx=%0d done=%b want %h %0d %b", i, q5[i].win, q5[i].idx, q5[i].dn, exp_win, i, (i == 2));
      end
      checks++;
      if (q5[i].cyc != q5[0].cyc + i) begin errors++; $display("FAIL b2b_gapless%0d: cyc=%0d want %0d", i, q5[i].cyc, q5[0].cyc + i); end
      checks++;
      if (pe_out(q5[i].win, q5[i].wt) !== exp_out[i]) begin
        errors++; $display("FAIL b2b_peout%0d: got %0d want %0d", i, pe_out(q5[i].win, q5[i].wt), exp_out[i]);
      end
    end
    checks++;
    if (wcnt5 != 1 || dcnt5 != 1) begin errors++; $display("FAIL b2b_pulses: wen=%0d done=%0d want 1 1", wcnt5, dcnt5); end
  endtask

  task automatic test_gaps();
    logic [23:0] exp_win;
    do_reset();
    start5 = 1'b1; step(); start5 = 1'b0;
    w_valid = 1'b1; w_data = 24'h010203; step(); w_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      px_valid = (i % 2 == 0); px_data = 8'(i / 2 + 1); step();
      if (i == 7) begin
        checks++;
        if (px_ready5 !== 1'b1) begin errors++; $display("FAIL gap_ready_mid: got %b want 1", px_ready5); end
      end
      if (i == 8) begin
        checks++;
        if (px_ready5 !== 1'b0 || done5 !== 1'b1) begin
          errors++; $display("FAIL gap_ready_end: px_ready=%b done=%b want 0 1", px_ready5, done5);
        end
      end
    end
    px_valid = 1'b0; step();
    checks++;
    if (q5.size() != 3) begin errors++; $display("FAIL gap_nwin: got %0d want 3", q5.size()); end
    for (int i = 0; i < q5.size() && i < 3; i++) begin
      exp_win = {8'(i + 1), 8'(i + 2), 8'(i + 3)};
      checks++;
      if (q5[i].win !== exp_win || q5[i].idx != i || q5[i].cyc != q5[0].cyc + 2 * i) begin
        errors++; $display("FAIL gap_win%0d: win=%h idx=%0d dcyc=%0d want %h %0d %0d", i, q5[i].win, q5[i].idx, q5[i].cyc - q5[0].cyc, exp_win, i, 2 * i);
      end
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    start5 = 1'b1; step();
    w_valid = 1'b1; w_data = 24'h020202; step(); w_valid = 1'b0; start5 = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      px_valid = 1'b1; px_data = 8'(p * 3); start5 = (p == 3); step();
    end
    px_valid = 1'b0;
    checks++;
    if (done5 !== 1'b1 || busy5 !== 1'b0) begin errors++; $display("FAIL busy_start_done: done=%b busy=%b want 1 0", done5, busy5); end
    start5 = 1'b1; step(); start5 = 1'b0;
    checks++;
    if ({w_ready5, busy5} !== 2'b11) begin errors++; $display("FAIL restart: w_ready,busy=%b want 11", {w_ready5, busy5}); end
    checks++;
    if (q5.size() != 3 || dcnt5 != 1 || wcnt5 != 1) begin
      errors++; $display("FAIL busy_start_stream: nwin=%0d done=%0d wen=%0d want 3 1 1", q5.size(), dcnt5, wcnt5);
    end
    checks++;
    if (q5.size() == 3 && q5[2].win !== 24'h090C0F) begin errors++; $display("FAIL busy_start_win: got %h want 090c0f", q5[2].win); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    start8 = 1'b1; step(); start8 = 1'b0;
    w_valid = 1'b1; w_data = 24'h010101; step(); w_valid = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      px_valid = 1'b1; px_data = 8'(p * 10); step();
    end
    checks++;
    if (pe_ce8 !== 1'b1 || pe_in1_8 !== 24'h0A141E) begin errors++; $display("FAIL mid_prewin: ce=%b in1=%h want 1 0a141e", pe_ce8, pe_in1_8); end
    rst_n = 1'b0; px_valid = 1'b0; step(); rst_n = 1'b1;
    checks++;
    if ({busy8, done8, w_ready8, px_ready8, pe_weight_en8, pe_ce8, pe_in2_8, pe_in1_8, win_idx8} !== 57'h0) begin
      errors++; $display("FAIL mid_rst_zero: ctrl=%b in2=%h in1=%h idx=%0d want 0", {busy8, done8, w_ready8, px_ready8, pe_weight_en8, pe_ce8}, pe_in2_8, pe_in1_8, win_idx8);
    end
    px_valid = 1'b1; step(); step(); px_valid = 1'b0;
    checks++;
    if (dcnt8 != 0 || busy8 !== 1'b0) begin errors++; $display("FAIL mid_no_done: done=%0d busy=%b want 0 0", dcnt8, busy8); end
    q8.delete();
    start8 = 1'b1; step(); start8 = 1'b0;
    w_valid = 1'b1; w_data = 24'h010101; step(); w_valid = 1'b0;
    for (int p = 1; p <= 8; p++) begin
      px_valid = 1'b1; px_data = 8'(p); step();
    end
    px_valid = 1'b0; step();
    checks++;
    if (q8.size() != 6 || dcnt8 != 1) begin errors++; $display("FAIL mid_rerun: nwin=%0d done=%0d want 6 1", q8.size(), dcnt8); end
    checks++;
    if (q8.size() == 6 && (q8[0].idx != 0 || q8[0].win !== 24'h010203 || q8[5].idx != 5 || q8[5].win !== 24'h060708 || q8[5].dn !== 1'b1)) begin
      errors++; $display("FAIL mid_rerun_win: first=%h/%0d last=%h/%0d/%b want 010203/0 060708/5/1", q8[0].win, q8[0].idx, q8[5].win, q8[5].idx, q8[5].dn);
    end
  endtask

  task automatic test_img3();
    do_reset();
    start3 = 1'b1; step(); start3 = 1'b0;
    w_valid = 1'b1; w_data = 24'hFFFFFF; step(); w_valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      px_valid = 1'b1; px_data = 8'hFF; step();
    end
    px_valid = 1'b0;
    checks++;
    if ({pe_ce3, done3, busy3} !== 3'b110 || pe_in1_3 !== 24'hFFFFFF || win_idx3 !== 2'd0) begin
      errors++; $display("FAIL img3_win: ce,done,busy=%b in1=%h idx=%0d want 110 ffffff 0", {pe_ce3, done3, busy3}, pe_in1_3, win_idx3);
    end
    checks++;
    if (pe_out(pe_in1_3, pe_in2_3) !== 18'd195075) begin errors++; $display("FAIL img3_peout: got %0d want 195075", pe_out(pe_in1_3, pe_in2_3)); end
    step();
    checks++;
    if (pe_ce3 !== 1'b0) begin errors++; $display("FAIL img3_single: ce=%b want 0", pe_ce3); end
  endtask

  task automatic test_w_valid_held();
    do_reset();
    w_valid = 1'b1; w_data = 24'h0A0B0C; step(); step();
    checks++;
    if (w_ready5 !== 1'b0 || wcnt5 != 0) begin errors++; $display("FAIL wheld_idle: w_ready=%b wen=%0d want 0 0", w_ready5, wcnt5); end
    start5 = 1'b1; step(); start5 = 1'b0;
    checks++;
    if (w_ready5 !== 1'b1 || wcnt5 != 0) begin errors++; $display("FAIL wheld_start: w_ready=%b wen=%0d want 1 0", w_ready5, wcnt5); end
    step();
    w_data = 24'h111111;
    checks++;
    if (pe_weight_en5 !== 1'b1 || pe_in2_5 !== 24'h0A0B0C) begin errors++; $display("FAIL wheld_take: wen=%b in2=%h want 1 0a0b0c", pe_weight_en5, pe_in2_5); end
    for (int p = 1; p <= 5; p++) begin
      px_valid = 1'b1; px_data = 8'(p); step();
      checks++;
      if (w_ready5 !== 1'b0) begin errors++; $display("FAIL wheld_stream%0d: w_ready=%b want 0", p, w_ready5); end
    end
    px_valid = 1'b0; step(); step();
    checks++;
    if (w_ready5 !== 1'b0 || wcnt5 != 1 || pe_in2_5 !== 24'h0A0B0C) begin
      errors++; $display("FAIL wheld_end: w_ready=%b wen=%0d in2=%h want 0 1 0a0b0c", w_ready5, wcnt5, pe_in2_5);
    end
    w_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_start_ignored();
    test_mid_reset();
    test_img3();
    test_w_valid_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
